// File: rtl/ff_pkg.sv
// rtl/ff_pkg.sv - shared ROM geometry constants and output beat type for the derivative fetch stage
//
// Contents:
//   ROM_ADDR_W/ROM_ROW_W/ROM_COL_W : neg_derivative_rom address split {row, col}
//   ROM_ROW_MAX/ROM_COL_MAX        : largest row/col index held by the ROM
//   DERIV_W/BEAT_IDX_W             : payload field widths of deriv_beat_t
//   deriv_beat_t                   : one output beat {deriv, idx, last}
package ff_pkg;

    localparam int ROM_ADDR_W  = 8;
    localparam int ROM_ROW_W   = 4;
    localparam int ROM_COL_W   = 4;
    localparam int ROM_ROW_MAX = 15;
    localparam int ROM_COL_MAX = 15;

    localparam int DERIV_W     = 16;
    localparam int BEAT_IDX_W  = 10;

    typedef struct packed {
        logic signed [DERIV_W-1:0]    deriv;
        logic        [BEAT_IDX_W-1:0] idx;
        logic                         last;
    } deriv_beat_t;

endpackage

// File: rtl/ff_sync_fifo.sv
// rtl/ff_sync_fifo.sv - register-based synchronous FIFO with occupancy count
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   push, push_data       : write request and data (ignored when full unless popping)
//   pop                   : read request (ignored when empty)
//   pop_data              : head entry, read straight from registers
//   empty                 : no entries held
//   count                 : number of entries held, 0..DEPTH
module ff_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_pop  = pop && !empty;
        // A pop in the same cycle frees the slot the push lands in.
        do_push = push && (!full || do_pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            // DEPTH is a power of two, so pointer overflow is the wrap.
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ff_derivative_fetch.sv
// rtl/ff_derivative_fetch.sv - quantizes (goodness, spike count) into neg_derivative_rom lookups and streams scaled derivatives
//
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   in_valid/in_ready                  : sample handshake
//   in_goodness/in_spike_cnt/in_idx    : sample payload (signed goodness, spike count, neuron index)
//   in_last                            : last sample of the frame
//   lr_shift                           : arithmetic right shift applied to the derivative
//   rom_addr/rom_dout                  : ROM address out, registered ROM data back one cycle later
//   out_valid/out_ready                : derivative handshake
//   out_deriv/out_idx/out_last         : scaled derivative, neuron index, frame last flag
//   frame_done                         : pulse in the cycle after the last beat handshakes
module ff_derivative_fetch
    import ff_pkg::*;
#(
    parameter int GOOD_WIDTH = 16,
    parameter int CNT_WIDTH  = 8,
    parameter int IDX_WIDTH  = BEAT_IDX_W,
    parameter int GOOD_SHIFT = 4,
    parameter int OUT_WIDTH  = DERIV_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [GOOD_WIDTH-1:0] in_goodness,
    input  logic        [CNT_WIDTH-1:0]  in_spike_cnt,
    input  logic        [IDX_WIDTH-1:0]  in_idx,
    input  logic                         in_last,
    input  logic        [3:0]            lr_shift,
    output logic        [ROM_ADDR_W-1:0] rom_addr,
    input  logic        [7:0]            rom_dout,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_WIDTH-1:0]  out_deriv,
    output logic        [IDX_WIDTH-1:0]  out_idx,
    output logic                         out_last,
    output logic                         frame_done
);

    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    // One extra bit so fifo_count + two pipeline slots cannot overflow.
    localparam int CRD_W  = FCNT_W + 1;
    localparam logic signed [GOOD_WIDTH-1:0] ROW_MAX_G = GOOD_WIDTH'(ROM_ROW_MAX);

    logic                        in_ready_q,   in_ready_d;
    logic [ROM_ADDR_W-1:0]       rom_addr_q,   rom_addr_d;
    logic                        a_valid_q,    a_valid_d;
    logic [IDX_WIDTH-1:0]        a_idx_q,      a_idx_d;
    logic                        a_last_q,     a_last_d;
    logic                        b_valid_q,    b_valid_d;
    logic [IDX_WIDTH-1:0]        b_idx_q,      b_idx_d;
    logic                        b_last_q,     b_last_d;
    logic                        frame_done_q, frame_done_d;

    logic                        accept;
    logic signed [GOOD_WIDTH-1:0] g;
    logic [ROM_ROW_W-1:0]        row;
    logic [ROM_COL_W-1:0]        col;
    logic signed [OUT_WIDTH-1:0] d_ext;
    logic signed [OUT_WIDTH-1:0] d_shift;
    logic                        pop;
    logic [CRD_W-1:0]            credit_used;

    deriv_beat_t                 push_beat;
    deriv_beat_t                 pop_beat;
    logic                        fifo_empty;
    logic [FCNT_W-1:0]           fifo_count;

    always_comb begin
        accept = in_valid && in_ready_q;

        // Quantizer: goodness picks the row, spike count picks the column.
        g = in_goodness >>> GOOD_SHIFT;
        if (g[GOOD_WIDTH-1]) begin
            row = '0;
        end else if (g > ROW_MAX_G) begin
            row = ROM_ROW_W'(ROM_ROW_MAX);
        end else begin
            row = g[ROM_ROW_W-1:0];
        end
        if (in_spike_cnt > CNT_WIDTH'(ROM_COL_MAX)) begin
            col = ROM_COL_W'(ROM_COL_MAX);
        end else begin
            col = in_spike_cnt[ROM_COL_W-1:0];
        end

        // Stage A: address goes to the ROM; rom_addr holds when idle.
        rom_addr_d = accept ? {row, col} : rom_addr_q;
        a_valid_d  = accept;
        a_idx_d    = accept ? in_idx  : a_idx_q;
        a_last_d   = accept ? in_last : a_last_q;

        // Stage B: aligned with the ROM's registered output.
        b_valid_d  = a_valid_q;
        b_idx_d    = a_idx_q;
        b_last_d   = a_last_q;

        d_ext   = OUT_WIDTH'($signed(rom_dout));
        d_shift = d_ext >>> lr_shift;

        push_beat.deriv = d_shift;
        push_beat.idx   = b_idx_q;
        push_beat.last  = b_last_q;

        pop = out_valid && out_ready;

        // Every accepted sample already owns a FIFO slot, so the ROM
        // pipeline never has to stall. Evaluated on next-cycle occupancy
        // to keep in_ready a flop.
        credit_used = CRD_W'(fifo_count) + CRD_W'(b_valid_q) - CRD_W'(pop)
                    + CRD_W'(a_valid_d) + CRD_W'(b_valid_d);
        in_ready_d  = (credit_used < CRD_W'(FIFO_DEPTH));

        frame_done_d = pop && pop_beat.last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q   <= 1'b0;
            rom_addr_q   <= '0;
            a_valid_q    <= 1'b0;
            a_idx_q      <= '0;
            a_last_q     <= 1'b0;
            b_valid_q    <= 1'b0;
            b_idx_q      <= '0;
            b_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            in_ready_q   <= in_ready_d;
            rom_addr_q   <= rom_addr_d;
            a_valid_q    <= a_valid_d;
            a_idx_q      <= a_idx_d;
            a_last_q     <= a_last_d;
            b_valid_q    <= b_valid_d;
            b_idx_q      <= b_idx_d;
            b_last_q     <= b_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    ff_sync_fifo #(
        .WIDTH ($bits(deriv_beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (b_valid_q),
        .push_data (push_beat),
        .pop       (pop),
        .pop_data  (pop_beat),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign in_ready   = in_ready_q;
    assign rom_addr   = rom_addr_q;
    assign out_valid  = !fifo_empty;
    assign out_deriv  = pop_beat.deriv;
    assign out_idx    = pop_beat.idx;
    assign out_last   = pop_beat.last;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ff_derivative_fetch.sv
// tb/tb_ff_derivative_fetch.sv - self-checking bench for ff_derivative_fetch with a reference ROM and scoreboard
module tb_ff_derivative_fetch;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_goodness;
    logic        [7:0]  in_spike_cnt;
    logic        [9:0]  in_idx;
    logic               in_last;
    logic        [3:0]  lr_shift;
    logic        [7:0]  rom_addr;
    logic        [7:0]  rom_dout;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_deriv;
    logic        [9:0]  out_idx;
    logic               out_last;
    logic               frame_done;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int deriv;
        int idx;
        bit last;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  rom_tbl [256];

    ff_derivative_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_goodness  (in_goodness),
        .in_spike_cnt (in_spike_cnt),
        .in_idx       (in_idx),
        .in_last      (in_last),
        .lr_shift     (lr_shift),
        .rom_addr     (rom_addr),
        .rom_dout     (rom_dout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_deriv    (out_deriv),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // neg_derivative_rom stand-in: registered read, one cycle latency.
    always @(posedge clk) rom_dout <= rom_tbl[rom_addr];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic int model_addr(input int goodness, input int cnt);
        int r;
        int c;
        r = floor_div(goodness, 16);
        if (r < 0)  r = 0;
        if (r > 15) r = 15;
        c = (cnt > 15) ? 15 : cnt;
        return r * 16 + c;
    endfunction

    function automatic int model_deriv(input int addr, input int sh);
        int v;
        v = int'(rom_tbl[addr]);
        if (v >= 128) v = v - 256;
        return floor_div(v, 1 << sh);
    endfunction

    // Output monitor: scoreboard compare on handshake, hold check under
    // backpressure, frame_done one cycle after the last beat.
    bit                prev_hs_last = 1'b0;
    bit                prev_stall   = 1'b0;
    logic signed [15:0] prev_deriv;
    logic        [9:0]  prev_idx;
    logic               prev_last;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            prev_hs_last = 1'b0;
            prev_stall   = 1'b0;
        end else begin
            check("frame_done", {15'b0, frame_done}, {15'b0, prev_hs_last});
            if (prev_stall) begin
                check("hold_valid", {15'b0, out_valid}, 16'd1);
                check("hold_deriv", out_deriv, prev_deriv);
                check("hold_idx", {6'b0, out_idx}, {6'b0, prev_idx});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("stale_beat", {15'b0, out_valid}, 16'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_deriv", out_deriv, 16'(e.deriv));
                    check("out_idx", {6'b0, out_idx}, 16'(e.idx));
                    check("out_last", {15'b0, out_last}, {15'b0, e.last});
                end
            end
            prev_hs_last = out_valid && out_ready && out_last;
            prev_stall   = out_valid && !out_ready;
            prev_deriv   = out_deriv;
            prev_idx     = out_idx;
            prev_last    = out_last;
            if (in_valid && in_ready) begin
                e.deriv = model_deriv(model_addr(int'(in_goodness), int'(in_spike_cnt)), int'(lr_shift));
                e.idx   = int'(in_idx);
                e.last  = in_last;
                sb.push_back(e);
            end
        end
    end

    task automatic set_sample(input int g, input int c, input int idx, input bit last);
        in_goodness  = 16'(g);
        in_spike_cnt = 8'(c);
        in_idx       = 10'(idx);
        in_last      = last;
    endtask

    // Holds in_valid until the sample is taken; returns just after the accepting edge.
    task automatic drive_wait();
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 200) check("accept_timeout", 16'd1, 16'd0);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    int d_g   [7] = '{0, 16, -5, 32767, 48, 0, 0};
    int d_c   [7] = '{0, 1, 3, 200, 0, 4, 4};
    int d_sh  [7] = '{0, 0, 0, 0, 0, 3, 15};
    int d_adr [7] = '{8'h00, 8'h11, 8'h03, 8'hFF, 8'h30, 8'h04, 8'h04};
    int d_der [7] = '{-15, -72, -109, 0, -60, -16, -1};

    initial begin
        int  lat;
        int  n;
        int  cyc;
        int  k;
        bit  acc;

        for (int a = 0; a < 256; a++) rom_tbl[a] = 8'((a * 37 + 5) % 256) | 8'h80;
        rom_tbl[8'h00] = 8'hF1;
        rom_tbl[8'h11] = 8'hB8;
        rom_tbl[8'h03] = 8'h93;
        rom_tbl[8'hFF] = 8'h00;
        rom_tbl[8'h30] = 8'hC4;
        rom_tbl[8'h04] = 8'h80;
        rom_tbl[8'h25] = 8'h05;
        rom_tbl[8'h7A] = 8'h3C;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        lr_shift  = 4'd0;
        set_sample(0, 0, 0, 1'b0);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {15'b0, in_ready}, 16'd0);
        check("rst_rom_addr", {8'b0, rom_addr}, 16'd0);
        check("rst_out_valid", {15'b0, out_valid}, 16'd0);
        check("rst_out_deriv", out_deriv, 16'd0);
        check("rst_out_idx", {6'b0, out_idx}, 16'd0);
        check("rst_out_last", {15'b0, out_last}, 16'd0);
        check("rst_frame_done", {15'b0, frame_done}, 16'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_rise", {15'b0, in_ready}, 16'd1);

        // Directed lookups: address mapping, latency, shift
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            lr_shift = 4'(d_sh[i]);
            set_sample(d_g[i], d_c[i], 100 + i, 1'b0);
            drive_wait();
            in_valid = 1'b0;
            lat = 1;
            @(negedge clk);
            check("rom_addr", {8'b0, rom_addr}, 16'(d_adr[i]));
            while (!out_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            check("latency", 16'(lat), 16'd3);
            check("dir_deriv", out_deriv, 16'(d_der[i]));
            check("dir_idx", {6'b0, out_idx}, 16'(100 + i));
            idle(3);
        end
        check("addr_hold", {8'b0, rom_addr}, 16'h04);

        // Backpressure: 10-sample frame with out_ready low
        lr_shift  = 4'd1;
        out_ready = 1'b0;
        n = 0;
        set_sample(n * 7 - 20, n, 200 + n, 1'b0);
        in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                n++;
                set_sample(n * 7 - 20, n, 200 + n, n == 9);
            end
        end
        check("bp_accepts", 16'(n), 16'd4);
        check("bp_in_ready", {15'b0, in_ready}, 16'd0);
        out_ready = 1'b1;
        cyc = 0;
        while (n < 10 && cyc < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                n++;
                set_sample(n * 7 - 20, n, 200 + n, n == 9);
            end
            cyc++;
        end
        in_valid = 1'b0;
        cyc = 0;
        while ((sb.size() != 0 || out_valid) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp_drained", 16'(sb.size()), 16'd0);
        idle(2);

        // Reset in the middle of a frame
        lr_shift  = 4'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_sample(40 + i * 9, i, 300 + i, 1'b0);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        check("pre_rst_valid", {15'b0, out_valid}, 16'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {15'b0, out_valid}, 16'd0);
        check("mid_rst_deriv", out_deriv, 16'd0);
        check("mid_rst_ready", {15'b0, in_ready}, 16'd0);
        check("mid_rst_addr", {8'b0, rom_addr}, 16'd0);
        in_valid = 1'b0;
        idle(2);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(8);
        check("post_rst_valid", {15'b0, out_valid}, 16'd0);

        // Randomized frame with random backpressure
        lr_shift = 4'($urandom_range(0, 7));
        k   = 0;
        cyc = 0;
        while (k < 60 && cyc < 3000) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 1) == 1)
                    set_sample($urandom_range(0, 400) - 120, $urandom_range(0, 24), k, k == 59);
                else
                    set_sample(int'($signed(16'($urandom))), $urandom_range(0, 255), k, k == 59);
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                in_valid = 1'b0;
                k++;
            end
            cyc++;
        end
        check("rand_sent", 16'(k), 16'd60);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while ((sb.size() != 0 || out_valid) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rand_drained", 16'(sb.size()), 16'd0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
